// File: rtl/letc_core_pkg.sv
// Shared types and helpers for the LETC Core caches and LIMP plumbing.
// Byte-enable and write-lane helpers assume LIMP write data is low-justified.
package letc_core_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] paddr_t;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALFWORD = 2'd1,
        SIZE_WORD     = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FLUSH
    } dmcache_state_e;

    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] be;
        case (size)
            SIZE_BYTE:     be = 4'b0001 << ofs;
            SIZE_HALFWORD: be = ofs[1] ? 4'b1100 : 4'b0011;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the low bytes across the word so the byte enables pick the right lane.
    function automatic word_t align_wr_data(input logic [1:0] size, input word_t data);
        word_t w;
        case (size)
            SIZE_BYTE:     w = {4{data[7:0]}};
            SIZE_HALFWORD: w = {2{data[15:0]}};
            default:       w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/letc_core_limp_if.sv
// LIMP request/response bundle between a requestor and a servicer.
interface letc_core_limp_if;
    import letc_core_pkg::*;

    logic       valid;
    logic       ready;
    logic       wen_nren;
    logic [1:0] size;
    paddr_t     addr;
    word_t      wr_data;
    word_t      rd_data;

    modport requestor (output valid, wen_nren, size, addr, wr_data, input ready, rd_data);
    modport servicer  (input valid, wen_nren, size, addr, wr_data, output ready, rd_data);

endinterface

// File: rtl/letc_core_dmcache_mem.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// one write port that can write a word, set a line valid, or clear a valid bit.
module letc_core_dmcache_mem
    import letc_core_pkg::*;
#(
    parameter int CACHE_DEPTH = 16,
    parameter int LINE_WORDS  = 4,
    parameter int TAG_W       = 26,
    localparam int IDX_W      = $clog2(CACHE_DEPTH),
    localparam int OFS_FW     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFS_FW-1:0] rd_ofs,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output word_t             rd_word,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFS_FW-1:0] wr_ofs,
    input  logic [3:0]        wr_be,
    input  word_t             wr_data,
    input  logic              set_valid,
    input  logic [TAG_W-1:0]  set_tag,
    input  logic              clr_valid
);

    logic [CACHE_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q  [CACHE_DEPTH];
    word_t                  data_q [CACHE_DEPTH][LINE_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_ofs];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
        end else if (clr_valid) begin
            valid_q[wr_idx] <= 1'b0;
        end else if (set_valid) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tags and data are left unreset; the valid bit alone qualifies them.
    always_ff @(posedge i_clk) begin
        if (set_valid) tag_q[wr_idx] <= set_tag;
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_q[wr_idx][wr_ofs][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/letc_core_dmcache.sv
// Direct-mapped, write-through, no-write-allocate cache between a stage and the AXI FSM.
// Define LETC_CORE_DMCACHE_WRITES_EN for the data-cache build; undefined gives a read-only cache.
module letc_core_dmcache
    import letc_core_pkg::*;
#(
    parameter int CACHE_DEPTH = 16,
    parameter int LINE_WORDS  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush_cache,
    output logic                o_flush_done,
    letc_core_limp_if.servicer  stage_limp,
    letc_core_limp_if.requestor axi_fsm_limp
);

    localparam int OFS_W  = $clog2(LINE_WORDS);
    localparam int OFS_FW = (OFS_W > 0) ? OFS_W : 1;
    localparam int IDX_W  = $clog2(CACHE_DEPTH);
    localparam int TAG_W  = ADDR_W - IDX_W - OFS_W - 2;
    localparam int CNT_W  = (IDX_W > OFS_FW) ? IDX_W : OFS_FW;
    localparam paddr_t LINE_MASK = paddr_t'(LINE_WORDS * 4 - 1);

    function automatic logic [IDX_W-1:0] idx_of(input paddr_t a);
        return IDX_W'(a >> (OFS_W + 2));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input paddr_t a);
        return TAG_W'(a >> (OFS_W + IDX_W + 2));
    endfunction

    function automatic logic [OFS_FW-1:0] ofs_of(input paddr_t a);
        return OFS_FW'(a >> 2) & OFS_FW'(LINE_WORDS - 1);
    endfunction

    dmcache_state_e state;
    logic [CNT_W-1:0] cnt;
    paddr_t           fill_base;
    logic             axi_valid;
    logic             flush_done;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    word_t             rd_word;
    logic              wr_en, set_valid, clr_valid;
    logic [IDX_W-1:0]  wr_idx;
    logic [OFS_FW-1:0] wr_ofs;
    logic [3:0]        wr_be;
    word_t             wr_data;

    logic hit, beat, last_beat, last_idx;

    assign hit       = rd_valid && (rd_tag == tag_of(stage_limp.addr));
    assign beat      = axi_valid && axi_fsm_limp.ready;
    assign last_beat = (cnt == CNT_W'(LINE_WORDS - 1));
    assign last_idx  = (cnt == CNT_W'(CACHE_DEPTH - 1));

    letc_core_dmcache_mem #(
        .CACHE_DEPTH (CACHE_DEPTH),
        .LINE_WORDS  (LINE_WORDS),
        .TAG_W       (TAG_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .rd_idx    (idx_of(stage_limp.addr)),
        .rd_ofs    (ofs_of(stage_limp.addr)),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_ofs    (wr_ofs),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .set_valid (set_valid),
        .set_tag   (tag_of(fill_base)),
        .clr_valid (clr_valid)
    );

    assign stage_limp.rd_data   = rd_word;
    assign axi_fsm_limp.valid   = axi_valid;
    assign axi_fsm_limp.wen_nren = (state == WRITE);
    assign axi_fsm_limp.size    = (state == WRITE) ? stage_limp.size : SIZE_WORD;
    assign axi_fsm_limp.addr    = (state == WRITE) ? stage_limp.addr
                                                   : (fill_base | (paddr_t'(cnt) << 2));
    assign axi_fsm_limp.wr_data = stage_limp.wr_data;
    assign o_flush_done         = flush_done;

    // Hit acknowledge is combinational; a pending flush masks it.
    always_comb begin
        stage_limp.ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (!i_flush_cache && stage_limp.valid) begin
`ifdef LETC_CORE_DMCACHE_WRITES_EN
                    stage_limp.ready = !stage_limp.wen_nren && hit;
`else
                    stage_limp.ready = stage_limp.wen_nren || hit;
`endif
                end
            end
`ifdef LETC_CORE_DMCACHE_WRITES_EN
            WRITE:   stage_limp.ready = axi_fsm_limp.ready;
`endif
            default: ;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        wr_idx    = idx_of(stage_limp.addr);
        wr_ofs    = ofs_of(stage_limp.addr);
        wr_be     = 4'hF;
        wr_data   = axi_fsm_limp.rd_data;
        unique case (state)
            FILL: begin
                wr_idx    = idx_of(fill_base);
                wr_ofs    = OFS_FW'(cnt);
                wr_en     = beat;
                set_valid = beat && last_beat;
            end
`ifdef LETC_CORE_DMCACHE_WRITES_EN
            WRITE: begin
                wr_en   = beat && hit;
                wr_be   = size_to_be(stage_limp.size, stage_limp.addr[1:0]);
                wr_data = align_wr_data(stage_limp.size, stage_limp.wr_data);
            end
`endif
            FLUSH: begin
                wr_idx    = IDX_W'(cnt);
                clr_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_base  <= '0;
            axi_valid  <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_flush_cache) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end else if (stage_limp.valid) begin
                        if (stage_limp.wen_nren) begin
`ifdef LETC_CORE_DMCACHE_WRITES_EN
                            state     <= WRITE;
                            axi_valid <= 1'b1;
`endif
                        end else if (!hit) begin
                            state     <= FILL;
                            cnt       <= '0;
                            fill_base <= stage_limp.addr & ~LINE_MASK;
                            axi_valid <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (beat) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state     <= IDLE;
                            axi_valid <= 1'b0;
                        end
                    end
                end
`ifdef LETC_CORE_DMCACHE_WRITES_EN
                WRITE: begin
                    if (beat) begin
                        state     <= IDLE;
                        axi_valid <= 1'b0;
                    end
                end
`endif
                FLUSH: begin
                    cnt        <= cnt + 1'b1;
                    // Registered pulse lands in the final sweep cycle.
                    flush_done <= (cnt == CNT_W'(CACHE_DEPTH - 2));
                    if (last_idx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef LETC_CORE_DMCACHE_WRITES_EN
    // A read-only cache acknowledges and drops writes; any write is a requestor bug.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(stage_limp.valid && stage_limp.wen_nren));
`endif

endmodule

// File: tb/tb_letc_core_dmcache.sv
// Self-checking bench for letc_core_dmcache: directed steps plus randomized traffic vs a line-residency model.
module tb_letc_core_dmcache;
    import letc_core_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = 4;
    localparam int LINE_BYTES = LW * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_done;

    letc_core_limp_if stage ();
    letc_core_limp_if axi ();

    letc_core_dmcache #(.CACHE_DEPTH(DEPTH), .LINE_WORDS(LW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush_cache (flush),
        .o_flush_done  (flush_done),
        .stage_limp    (stage),
        .axi_fsm_limp  (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [1:0]  size;
        logic [31:0] data;
    } beat_t;

    beat_t beats[$];
    bit [31:0] bmem [bit [31:0]];
    int checks = 0;
    int failures = 0;
    int flush_pulses = 0;
    int lat = 0;
    int max_lat = 2;
    bit beat_start = 1'b1;

    // Reference: which line (address / LINE_BYTES) is resident in each slot.
    bit          mvalid [DEPTH];
    logic [31:0] mline  [DEPTH];

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        logic [31:0] w;
        if (bmem.exists(a)) return bmem[a];
        w = {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
        return w;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        int o;
        w = bmem_rd(a & ~32'd3);
        o = int'(a & 32'd3);
        if (size == 2'd0)      w[8*o +: 8] = d[7:0];
        else if (size == 2'd1) w[16*(o/2) +: 16] = d[15:0];
        else                   w = d;
        bmem[a & ~32'd3] = w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // AXI-side responder: random wait states, backing memory, beat log.
    always @(negedge clk) begin
        if (flush_done === 1'b1) flush_pulses++;
        if (axi.valid === 1'b1 && axi.ready === 1'b1) begin
            beats.push_back('{axi.addr, axi.wen_nren, axi.size, axi.wr_data});
            if (axi.wen_nren) mem_write(axi.addr, axi.size, axi.wr_data);
            beat_start = 1'b1;
        end
    end

    initial begin
        axi.ready = 1'b0;
        axi.rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (axi.valid === 1'b1) begin
                if (beat_start) begin
                    lat = $urandom_range(0, max_lat);
                    beat_start = 1'b0;
                end else if (lat > 0) begin
                    lat--;
                end
                axi.ready = (lat == 0);
                axi.rd_data = bmem_rd(axi.addr);
            end else begin
                axi.ready = 1'b0;
                beat_start = 1'b1;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
    endtask

    // Called and returns at posedge+2.
    task automatic do_read(input logic [31:0] a, input string tag, output logic [31:0] rd);
        int idx;
        logic [31:0] line;
        bit exp_hit;
        int cyc, vcyc;
        bit got;
        idx = int'((a / LINE_BYTES) % DEPTH);
        line = a / LINE_BYTES;
        exp_hit = mvalid[idx] && (mline[idx] == line);
        cyc = 0;
        vcyc = 0;
        got = 1'b0;
        rd = 'x;
        beats.delete();
        stage.valid = 1'b1;
        stage.wen_nren = 1'b0;
        stage.addr = a;
        stage.size = 2'd2;
        stage.wr_data = '0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (axi.valid === 1'b1) vcyc++;
            if (stage.ready === 1'b1) begin
                got = 1'b1;
                rd = stage.rd_data;
            end
        end
        @(posedge clk);
        #2;
        stage.valid = 1'b0;
        check({tag, "_ack"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_data"}, rd, bmem_rd(a & ~32'd3));
            if (exp_hit) begin
                check({tag, "_hit_lat"}, 32'(cyc), 32'd1);
                check({tag, "_hit_beats"}, 32'(beats.size()), 32'd0);
            end else begin
                check({tag, "_miss_lat"}, 32'(cyc), 32'(vcyc + 2));
                check({tag, "_miss_beats"}, 32'(beats.size()), 32'(LW));
                for (int i = 0; i < LW && i < beats.size(); i++) begin
                    check({tag, "_fill_addr"}, beats[i].addr, line * LINE_BYTES + 32'(4 * i));
                    check({tag, "_fill_wen"}, 32'(beats[i].wen), 32'd0);
                end
            end
            mvalid[idx] = 1'b1;
            mline[idx] = line;
        end
    endtask

`ifdef LETC_CORE_DMCACHE_WRITES_EN
    task automatic do_write(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d, input string tag);
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        beats.delete();
        stage.valid = 1'b1;
        stage.wen_nren = 1'b1;
        stage.addr = a;
        stage.size = size;
        stage.wr_data = d;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (stage.ready === 1'b1) got = 1'b1;
        end
        @(posedge clk);
        #2;
        stage.valid = 1'b0;
        stage.wen_nren = 1'b0;
        check({tag, "_ack"}, 32'(got), 32'd1);
        check({tag, "_nbeats"}, 32'(beats.size()), 32'd1);
        if (beats.size() >= 1) begin
            check({tag, "_addr"}, beats[0].addr, a);
            check({tag, "_wen"}, 32'(beats[0].wen), 32'd1);
            check({tag, "_size"}, 32'(beats[0].size), 32'(size));
            check({tag, "_data"}, beats[0].data, d);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int cyc, p0, rdy;
        stage.valid = 1'b0;
        stage.wen_nren = 1'b0;
        stage.addr = '0;
        stage.size = 2'd2;
        stage.wr_data = '0;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_axi_valid", 32'(axi.valid), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_stage_ready", 32'(stage.ready), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_axi_valid", 32'(axi.valid), 32'd0);
        check("post_rst_flush_done", 32'(flush_done), 32'd0);
        @(posedge clk);
        #2;

        // Fill, hit, evict
        bmem[32'h40] = 32'h1122_3344;
        do_read(32'h40, "miss40", rd);
        check("miss40_word", rd, 32'h1122_3344);
        do_read(32'h40, "hit40", rd);
        do_read(32'h440, "evict440", rd);
        do_read(32'h40, "remiss40", rd);

`ifdef LETC_CORE_DMCACHE_WRITES_EN
        do_write(32'h41, 2'd0, 32'h0000_00AB, "wbyte41");
        do_read(32'h40, "rd_merged40", rd);
        check("merged_word", rd, 32'h1122_AB44);
        do_write(32'h804, 2'd2, 32'hDEAD_BEEF, "wmiss804");
        do_read(32'h804, "rd_after_wmiss", rd);
        check("wmiss_word", rd, 32'hDEAD_BEEF);
`endif

        // Flush sweep, with a resident-line read masked by flush priority
        do_read(32'h0, "fill_idx0", rd);
        do_read(32'h50, "fill_idx5", rd);
        do_read(32'h50, "hit_idx5", rd);
        p0 = flush_pulses;
        flush = 1'b1;
        stage.valid = 1'b1;
        stage.wen_nren = 1'b0;
        stage.addr = 32'h50;
        rdy = 0;
        @(negedge clk);
        if (stage.ready === 1'b1) rdy++;
        check("flush_done_early", 32'(flush_done), 32'd0);
        @(posedge clk);
        #2;
        flush = 1'b0;
        cyc = 1;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (stage.ready === 1'b1) rdy++;
            if (flush_done === 1'b1) break;
        end
        check("flush_cycles", 32'(cyc), 32'(DEPTH + 1));
        check("flush_no_ready", 32'(rdy), 32'd0);
        @(posedge clk);
        #2;
        stage.valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("flush_one_pulse", 32'(flush_pulses - p0), 32'd1);
        clear_model();
        do_read(32'h0, "post_flush_idx0", rd);
        do_read(32'h50, "post_flush_idx5", rd);

        // Flush raised mid-fill is ignored and not re-sampled once dropped
        p0 = flush_pulses;
        fork
            do_read(32'h1040, "fill_w_flush", rd);
            begin
                int w;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (beats.size() < 1 && w < 100);
                @(posedge clk);
                #2;
                flush = 1'b1;
                @(posedge clk);
                #2;
                flush = 1'b0;
            end
        join
        repeat (DEPTH + 4) @(posedge clk);
        #2;
        check("mid_fill_flush_ignored", 32'(flush_pulses - p0), 32'd0);
        do_read(32'h1044, "hit_after_flush_fill", rd);

        // Reset mid-fill leaves the line invalid
        beats.delete();
        stage.valid = 1'b1;
        stage.wen_nren = 1'b0;
        stage.addr = 32'h2080;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (beats.size() < 1 && cyc < 100);
        #1;
        rst_n = 1'b0;
        stage.valid = 1'b0;
        @(negedge clk);
        check("midfill_rst_axi_valid", 32'(axi.valid), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_model();
        do_read(32'h2080, "after_rst_fill", rd);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int op;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2);
            op = $urandom_range(0, 9);
`ifdef LETC_CORE_DMCACHE_WRITES_EN
            if (op < 3) begin
                logic [1:0] sz;
                logic [31:0] wa;
                sz = 2'($urandom_range(0, 2));
                wa = a | 32'($urandom_range(0, 3));
                if (sz == 2'd1) wa = wa & ~32'd1;
                if (sz == 2'd2) wa = wa & ~32'd3;
                do_write(wa, sz, $urandom, "rnd_write");
            end else begin
                do_read(a, "rnd_read", rd);
            end
`else
            if (op >= 0) do_read(a, "rnd_read", rd);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/letc_core_dmcache.md
# letc_core_dmcache

Parametrised direct-mapped, write-through, no-write-allocate cache for the LETC Core. One instance serves as the instruction cache and another as the data cache. It sits between a pipeline stage's LIMP requestor and the AXI FSM's LIMP servicer. It replaces the stub cache with real tag/data storage, a line-fill state machine, and a timed flush sweep that reports completion.

## Interface
- CACHE_DEPTH, 16: number of lines; power of two, at least 2.
- LINE_WORDS, 4: 32-bit words per line; power of two, at least 1.
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush_cache  in  1  level request to invalidate all lines.
- o_flush_done  out  1  one-cycle pulse when the flush sweep completes.
- stage_limp  letc_core_limp_if.servicer  -  requests from the stage. Uses valid, ready, wen_nren, size, addr[31:0], wr_data[31:0], rd_data[31:0].
- axi_fsm_limp  letc_core_limp_if.requestor  -  fills and write-throughs to the AXI FSM; same signals.

## Operation
- Address split: offset = addr[OFS_W+1:2], where OFS_W = log2(LINE_WORDS). Index = next log2(CACHE_DEPTH) bits. Tag = the remaining upper bits.
- Per-line state: valid bit (reset to 0), tag, and LINE_WORDS data words. Data and tags are not reset.
- Reads return the aligned 32-bit word. The stage extracts sub-word data.
- FSM states: IDLE, FILL, WRITE, FLUSH.
- IDLE transitions:
  - If i_flush_cache is high, go to FLUSH and clear the sweep counter. Flush has priority over a stage request in the same cycle.
  - Read with valid line and matching tag (hit): assert ready with rd_data in the same cycle. Stay in IDLE.
  - Read miss: go to FILL. Clear the fill counter and latch the line address.
  - Write (macro enabled): go to WRITE.
- FILL: issue LINE_WORDS word reads on axi_fsm_limp in order, offset 0 first, at {tag, index, word, 2'b00}.
  - Each word is written into the line when axi_fsm_limp.ready is high.
  - After the last word: set valid, store the tag, return to IDLE. The held request then hits.
- WRITE: forward addr, size and wr_data to axi_fsm_limp.
  - When axi_fsm_limp.ready is high: assert stage_limp.ready and return to IDLE.
  - If the line hits, merge the written bytes into the stored word (byte, halfword or word per size). A miss does not allocate.
- FLUSH: clear one valid bit per cycle, index 0 up to CACHE_DEPTH-1. No stage ready is issued.
  - After the last index: pulse o_flush_done, return to IDLE.
  - i_flush_cache still high in IDLE starts a new sweep.
- i_flush_cache raised during FILL or WRITE is ignored until the FSM returns to IDLE. The level is re-sampled there.

## Timing
- Reset values: state IDLE, all valid bits 0, stage_limp.ready 0, axi_fsm_limp.valid 0, o_flush_done 0, counters 0.
- A reset mid-fill abandons the fill. The line stays invalid.
- Read hit: 0-cycle latency (ready combinational from valid, tag and valid bit).
- Read miss: returns to IDLE the cycle after the last fill beat; ready is asserted in that IDLE cycle. Latency = 1 + sum of the beat latencies + 1.
- axi_fsm_limp.valid is registered. It stays high with stable addr until ready, then drops or moves to the next beat in the following cycle.
- Flush: exactly CACHE_DEPTH cycles in FLUSH. o_flush_done is high in the last FLUSH cycle.
- stage_limp inputs must stay stable while valid is high and ready is low.

## Configuration
- LETC_CORE_DMCACHE_WRITES_EN.
  - Defined: WRITE state exists and write-through with hit update is implemented.
  - Undefined (read-only instruction cache): WRITE state and merge logic are removed. A write request is answered with ready in the same cycle, nothing is forwarded, and an assertion fires in simulation.

## Structure
- In letc_core_pkg:
  - enum dmcache_state_e {IDLE, FILL, WRITE, FLUSH}.
  - Word and address widths (32).
  - Helper functions for byte-enable from size and addr[1:0].
- Sub-module letc_core_dmcache_mem: valid/tag/data arrays with a combinational read port and a single write port (line-valid set, word write with byte enables, valid clear).

## Test plan
- Reset, then read 0x0000_0040: FILL issues 0x40, 0x44, 0x48, 0x4C. Ready is returned with the word from 0x40. A repeat read hits with ready in the same cycle and no axi_fsm_limp.valid.
- Fill line 0x40, then read 0x0000_0440 (same index, different tag with default params): the FSM re-fills and evicts. A subsequent read of 0x40 misses.
- Byte write 0xAB to 0x41 on a hit line holding 0x1122_3344: forwarded with size byte. A later read returns 0x1122_AB44.
- Write to a miss address: forwarded only. The next read of that address still misses.
- Fill lines at indices 0 and 5, assert i_flush_cache for 1 cycle: 16 FLUSH cycles, o_flush_done pulses once. Both lines then miss.
- Assert flush during FILL beat 2: the fill completes and the read returns. FLUSH starts in the next IDLE cycle only if flush is still high.
